// File: rtl/video_capture_fb.sv
// Video input capture: registers the incoming stream, writes active pixels to a
// framebuffer write port, and measures line/frame timing with a lock detector.
module video_capture_fb #(
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 12,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              data_en,
  input  logic [7:0]        tmds_0,
  input  logic [7:0]        tmds_1,
  input  logic [7:0]        tmds_2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              frame_sync,
  output logic              addr_wrap,
  output logic [CNT_W-1:0]  htotal,
  output logic [CNT_W-1:0]  vtotal,
  output logic [CNT_W-1:0]  hres,
  output logic [CNT_W-1:0]  vres,
  output logic              locked
);

  localparam int MC_W = $clog2(LOCK_FRAMES + 1);

  typedef enum logic {WAIT_VSYNC, CAPTURE} cap_state_t;
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic              hs_p1, hs_p2, vs_p1, vs_p2, vld_p1, vld_p2;
  logic [23:0]       pix_p1;
  logic              vs_edge, hs_edge, de_fall, capturing, new_act, latch, meas_match;
  cap_state_t        cap_state, cap_next;
  lock_state_t       lock_state, lock_next;
  logic [MC_W-1:0]   match_cnt, mc_next;
  logic [ADDR_W-1:0] addr_ptr;
  logic              wrap_pend, line_act, armed;
  logic [CNT_W-1:0]  hclk_cnt, line_htotal, pix_cnt, line_hres, line_cnt, act_cnt;

  // Stage p1/p2: input registers; these only follow the pins, so no reset is needed
  always_ff @(posedge clk) begin
    hs_p1  <= hsync;
    vs_p1  <= vsync;
    vld_p1 <= data_en;
    pix_p1 <= {tmds_2, tmds_1, tmds_0};
    hs_p2  <= hs_p1;
    vs_p2  <= vs_p1;
    vld_p2 <= vld_p1;
  end

  assign vs_edge   = (vs_p1 == SYNC_POL) && (vs_p2 != SYNC_POL);
  assign hs_edge   = (hs_p1 == SYNC_POL) && (hs_p2 != SYNC_POL);
  assign de_fall   = vld_p2 && !vld_p1;
  // The vsync-edge cycle already belongs to the new frame, even when leaving WAIT_VSYNC
  assign capturing = (cap_state == CAPTURE) || vs_edge;
  assign new_act   = vld_p1 && (hs_edge || !line_act);
  assign latch     = vs_edge && armed;
  assign meas_match = ({line_htotal, line_cnt, line_hres, act_cnt} ==
                       {htotal, vtotal, hres, vres});

  always_comb begin
    cap_next = cap_state;
    if (cap_state == WAIT_VSYNC && vs_edge) cap_next = CAPTURE;
  end

  always_comb begin
    lock_next = lock_state;
    mc_next   = match_cnt;
    if (latch) begin
      if (meas_match) begin
        mc_next = (match_cnt >= MC_W'(LOCK_FRAMES)) ? MC_W'(LOCK_FRAMES) : match_cnt + 1'b1;
        if (mc_next == MC_W'(LOCK_FRAMES)) lock_next = LOCKED;
      end else begin
        mc_next   = '0;
        lock_next = UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state  <= WAIT_VSYNC;
      lock_state <= UNLOCKED;
      match_cnt  <= '0;
    end else begin
      cap_state  <= cap_next;
      lock_state <= lock_next;
      match_cnt  <= mc_next;
    end
  end

  assign locked = (lock_state == LOCKED);

  // Stage p3: write port, line/frame measurement and latched timing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_sync  <= 1'b0;
      addr_wrap   <= 1'b0;
      addr_ptr    <= '0;
      wrap_pend   <= 1'b0;
      hclk_cnt    <= '0;
      line_htotal <= '0;
      pix_cnt     <= '0;
      line_hres   <= '0;
      line_cnt    <= '0;
      act_cnt     <= '0;
      line_act    <= 1'b0;
      armed       <= 1'b0;
      htotal      <= '0;
      vtotal      <= '0;
      hres        <= '0;
      vres        <= '0;
    end else begin
      frame_sync <= vs_edge;
      wr_en      <= capturing && vld_p1;
      addr_wrap  <= 1'b0;
      if (capturing && vld_p1) wr_data <= {8'h00, pix_p1};

      // wrap_pend marks that the pointer rolled over, so the next write at 0 is a wrap
      if (vs_edge) begin
        wrap_pend <= 1'b0;
        if (vld_p1) begin
          wr_addr  <= '0;
          addr_ptr <= ADDR_W'(1);
        end else begin
          addr_ptr <= '0;
        end
      end else if (capturing && vld_p1) begin
        wr_addr   <= addr_ptr;
        addr_ptr  <= addr_ptr + 1'b1;
        wrap_pend <= (addr_ptr == {ADDR_W{1'b1}});
        addr_wrap <= wrap_pend;
      end

      if (hs_edge) begin
        line_htotal <= sat_inc(hclk_cnt);
        hclk_cnt    <= '0;
      end else begin
        hclk_cnt <= sat_inc(hclk_cnt);
      end

      if (de_fall) begin
        line_hres <= pix_cnt;
        pix_cnt   <= '0;
      end else if (vld_p1) begin
        pix_cnt <= sat_inc(pix_cnt);
      end

      line_act <= hs_edge ? vld_p1 : (line_act | vld_p1);

      if (vs_edge) begin
        armed    <= 1'b1;
        line_cnt <= hs_edge ? CNT_W'(1) : '0;
        act_cnt  <= new_act ? CNT_W'(1) : '0;
        if (armed) begin
          htotal <= line_htotal;
          hres   <= line_hres;
          vtotal <= line_cnt;
          vres   <= act_cnt;
        end
      end else begin
        if (hs_edge) line_cnt <= sat_inc(line_cnt);
        if (new_act) act_cnt <= sat_inc(act_cnt);
      end
    end
  end

endmodule
